// File: rtl/first_counter_pkg.sv
// first_counter_pkg
//   Shared definitions for the first_counter_monitor block:
//   - state_t    : monitor state enumeration (IDLE, TRACK, FAULT)
//   - ERR_*      : 2-bit fault codes reported on err_code
//   - CNT_W_DEF  : default width of the monitored upstream counter
package first_counter_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SKIP = 2'b01;
    localparam logic [1:0] ERR_HOLD = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;

endpackage

// File: rtl/rise_detect.sv
// rise_detect
//   Registered rising-edge detector. The previous value of sig is held in a
//   flop; rise is high in the cycle where sig is 1 and was 0 one cycle ago.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous, active-low reset (clears the history flop)
//   sig   in  1  signal to watch
//   rise  out 1  sig & ~sig_delayed
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/first_counter_monitor.sv
// first_counter_monitor
//   Watches an upstream free-running counter and its overflow flag. After the
//   first enabled sample it tracks the counter, counts all-ones->0 wraps
//   (saturating) and latches the first detected fault into a sticky error.
// Ports:
//   clk         in  1       rising-edge clock
//   reset       in  1       synchronous, active-low reset
//   enable      in  1       enable driving the upstream counter
//   counter_in  in  CNT_W   upstream counter value
//   overflow_in in  1       upstream overflow flag
//   tracking    out 1       high while state is TRACK
//   wrap_count  out WRAP_W  number of observed wraps, saturating
//   error       out 1       sticky fault flag
//   err_code    out 2       first fault: 00 none, 01 SKIP, 10 HOLD, 11 OVF
module first_counter_monitor
    import first_counter_pkg::*;
#(
    parameter int WRAP_W = 8,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              overflow_in,
    output logic              tracking,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [CNT_W-1:0]  CNT_ONES = {CNT_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] last;
    logic             en_d;
    logic             ovf_rise;
    logic [CNT_W-1:0] expected;
    logic             skip_flt;
    logic             hold_flt;
    logic             ovf_flt;
    logic             wrap_hit;
    logic [1:0]       fault_code;

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (v == WRAP_MAX) ? v : v + WRAP_W'(1);
    endfunction

    rise_detect u_ovf_rise (
        .clk   (clk),
        .reset (reset),
        .sig   (overflow_in),
        .rise  (ovf_rise)
    );

    // Per-sample checks, evaluated against the previous sample (last) and the
    // enable that was in force when the upstream counter produced counter_in.
    assign expected = last + CNT_W'(1);
    assign skip_flt = en_d && (counter_in != expected);
    // A drop to zero while disabled is an upstream reset, not a hold fault.
    assign hold_flt = !en_d && (counter_in != last) && (counter_in != '0);
    assign ovf_flt  = ovf_rise && (counter_in != CNT_ONES) && (last != CNT_ONES);
    assign wrap_hit = en_d && (last == CNT_ONES) && (counter_in == '0);

    always_comb begin
        fault_code = ERR_NONE;
        if (skip_flt) begin
            fault_code = ERR_SKIP;
        end else if (hold_flt) begin
            fault_code = ERR_HOLD;
        end else if (ovf_flt) begin
            fault_code = ERR_OVF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last       <= '0;
            en_d       <= 1'b0;
            tracking   <= 1'b0;
            wrap_count <= '0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            en_d <= enable;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        last     <= counter_in;
                        state    <= ST_TRACK;
                        tracking <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (fault_code != ERR_NONE) begin
                        state    <= ST_FAULT;
                        tracking <= 1'b0;
                        error    <= 1'b1;
                        err_code <= fault_code;
                    end else begin
                        last <= counter_in;
                        if (wrap_hit) begin
                            wrap_count <= sat_inc(wrap_count);
                        end
                    end
                end
                ST_FAULT: begin
                    // Absorbing: only reset leaves this state.
                end
                default: begin
                    state    <= ST_IDLE;
                    tracking <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_first_counter_monitor.sv
// tb_first_counter_monitor
//   Directed scenarios plus randomized traffic for first_counter_monitor.
//   Two instances share the stimulus: default WRAP_W=8 and WRAP_W=2.
//   Expected outputs come from a behavioural model of the monitoring rules.
module tb_first_counter_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] counter_in;
    logic       overflow_in;

    logic       trk8, err8;
    logic [7:0] wrap8;
    logic [1:0] code8;
    logic       trk2, err2;
    logic [1:0] wrap2;
    logic [1:0] code2;

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 tracking, 2 faulted
    int m_state, m_last, m_wrap, m_code, m_en_d, m_ovf_d;
    int up;

    always #5 clk = ~clk;

    first_counter_monitor dut8 (
        .clk(clk), .reset(reset), .enable(enable), .counter_in(counter_in),
        .overflow_in(overflow_in), .tracking(trk8), .wrap_count(wrap8),
        .error(err8), .err_code(code8)
    );

    first_counter_monitor #(.WRAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .counter_in(counter_in),
        .overflow_in(overflow_in), .tracking(trk2), .wrap_count(wrap2),
        .error(err2), .err_code(code2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rn, input bit en, input int c, input bit ov);
        if (!rn) begin
            m_state = 0; m_last = 0; m_wrap = 0; m_code = 0; m_en_d = 0; m_ovf_d = 0;
        end else begin
            if (m_state == 0) begin
                if (en) begin
                    m_last  = c;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                int code;
                code = 0;
                if (m_en_d == 1 && c != (m_last + 1) % 16)
                    code = 1;
                else if (m_en_d == 0 && c != m_last && c != 0)
                    code = 2;
                else if (ov && m_ovf_d == 0 && c != 15 && m_last != 15)
                    code = 3;
                if (code != 0) begin
                    m_state = 2;
                    m_code  = code;
                end else begin
                    if (m_en_d == 1 && m_last == 15 && c == 0) m_wrap++;
                    m_last = c;
                end
            end
            m_en_d  = en ? 1 : 0;
            m_ovf_d = ov ? 1 : 0;
        end
    endtask

    task automatic tick(input bit rn, input bit en, input int c, input bit ov);
        @(negedge clk);
        reset       = rn;
        enable      = en;
        counter_in  = 4'(c);
        overflow_in = ov;
        @(posedge clk);
        model(rn, en, c, ov);
        #1;
        chk("tracking8",  32'(trk8),  32'(m_state == 1));
        chk("error8",     32'(err8),  32'(m_state == 2));
        chk("err_code8",  32'(code8), 32'(m_code));
        chk("wrap8",      32'(wrap8), 32'((m_wrap > 255) ? 255 : m_wrap));
        chk("tracking2",  32'(trk2),  32'(m_state == 1));
        chk("error2",     32'(err2),  32'(m_state == 2));
        chk("err_code2",  32'(code2), 32'(m_code));
        chk("wrap2",      32'(wrap2), 32'((m_wrap > 3) ? 3 : m_wrap));
    endtask

    // Upstream counter: sample shows up, enable advances it for next cycle.
    task automatic count(input int n, input bit en);
        repeat (n) begin
            tick(1'b1, en, up, up == 15);
            if (en) up = (up + 1) % 16;
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) tick(1'b0, 1'b0, 0, 1'b0);
        up = 0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; counter_in = '0; overflow_in = 1'b0;
        m_state = 0; m_last = 0; m_wrap = 0; m_code = 0; m_en_d = 0; m_ovf_d = 0;
        up = 0;

        // Basic run through one wrap with overflow at 15
        do_reset(2);
        count(20, 1'b1);

        // Skip 5->7
        do_reset(2);
        count(6, 1'b1);
        tick(1'b1, 1'b1, 7, 1'b0);
        up = 8;
        count(3, 1'b1);

        // Hold violation 9->10 while disabled
        do_reset(1);
        count(9, 1'b1);
        count(2, 1'b0);
        tick(1'b1, 1'b0, 10, 1'b0);
        count(2, 1'b0);

        // Upstream reset 9->0 while disabled, then resume counting
        do_reset(1);
        count(9, 1'b1);
        count(2, 1'b0);
        tick(1'b1, 1'b0, 0, 1'b0);
        up = 0;
        count(3, 1'b0);
        count(20, 1'b1);

        // Overflow rising at 6
        do_reset(1);
        count(6, 1'b1);
        tick(1'b1, 1'b1, 6, 1'b1);
        count(2, 1'b1);

        // Skip and overflow in the same sample
        do_reset(1);
        count(6, 1'b1);
        tick(1'b1, 1'b1, 8, 1'b1);
        count(2, 1'b1);

        // Five full wraps: saturation of the narrow instance
        do_reset(1);
        count(84, 1'b1);

        // Reset while faulted, then normal tracking
        do_reset(1);
        count(5, 1'b1);
        tick(1'b1, 1'b1, 9, 1'b0);
        count(2, 1'b1);
        do_reset(1);
        count(20, 1'b1);

        // Randomized traffic with occasional glitches, upstream resets and resets
        for (int r = 0; r < 12; r++) begin
            do_reset(1 + int'($urandom_range(0, 1)));
            for (int i = 0; i < 60; i++) begin
                int  p, c;
                bit  en, ov, rn;
                p  = int'($urandom_range(0, 99));
                en = ($urandom_range(0, 9) < 7);
                if (p < 4)
                    c = int'($urandom_range(0, 15));
                else if (p < 8 && !en)
                    c = 0;
                else
                    c = up;
                ov = (c == 15) || (p >= 8 && p < 12);
                rn = (p != 99);
                tick(rn, en, c, ov);
                if (!rn) up = 0;
                else up = en ? (c + 1) % 16 : c;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
